bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/arb_pkg.sv | 25 ++
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/mux4.sv | 29 ++
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the bus_arbiter slice: requester count, the
// arbiter state encoding, the hold-counter width and a one-hot helper.
// No ports (package).
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Convert a requester index into its one-hot grant pattern.
    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Scans requesters starting one past
// the last owner and wrapping, so the last owner itself is visited last.
// Ports:
//   req   : request vector (NREQ bits)
//   last  : index of the most recent owner
//   found : high when any request bit is set
//   idx   : index of the first requester found in round-robin order
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic            found,
    output logic [1:0]      idx
);

    // Walk offsets 1..NREQ from the last owner; the 2-bit sum wraps modulo 4,
    // and offset NREQ lands back on the last owner as the lowest rank.
    always_comb begin
        logic [1:0] cand;
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4.sv
// ---------------------------------------------------------------------------
// mux4
// Library 4:1 multiplexer cell, parameterised on data width.
// Ports:
//   d0..d3 : data inputs, W bits each
//   s      : 2-bit select
//   y      : selected data word
// ---------------------------------------------------------------------------
module mux4 #(
    parameter int W = 16
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   s,
    output logic [W-1:0] y
);

    always_comb begin
        unique case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Four-requester round-robin bus arbiter with registered one-hot grant and
// a shared data bus driven from the current owner's word.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to add a hold counter that
// forces a handover after MAX_HOLD consecutive grant cycles when another
// requester is waiting. Default build has no hold counter.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-low reset
//   req    : per-requester level-sensitive request
//   in0..3 : requester data words (WIDTH bits)
//   grant  : registered one-hot grant, zero when idle
//   sel    : registered index of current owner
//   valid  : registered, high while a grant is active
//   dout   : owner's word when valid, otherwise zero
// ---------------------------------------------------------------------------
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] sel_d;
    logic [3:0] grant_d;
    logic       valid_d;
    logic       found;
    logic [1:0] pick;
    logic       timeout;
    logic [WIDTH-1:0] mux_y;

    rr_pick u_pick (
        .req   (req),
        .last  (last_q),
        .found (found),
        .idx   (pick)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // hold_q counts completed owned cycles, so the edge that ends the
    // MAX_HOLD-th cycle sees MAX_HOLD-1; saturation keeps it at or above.
    assign timeout = valid && (hold_q >= HOLD_LIMIT - HOLD_W'(1))
                     && ((req & ~grant) != 4'b0000);

    // Clear on any grant change, otherwise count owned cycles up to the limit.
    always_comb begin
        hold_d = hold_q;
        if (grant_d != grant) begin
            hold_d = '0;
        end else if (state_q == OWNED && hold_q != HOLD_LIMIT) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and output registers; grant, sel and valid always load together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            grant   <= 4'b0000;
            sel     <= 2'd0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant   <= grant_d;
            sel     <= sel_d;
            valid   <= valid_d;
        end
    end

    // Next-state logic. A release (or forced timeout) searches from the
    // current owner + 1, which ranks the releasing requester lowest and
    // hands over at the same edge when anyone else is waiting.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant;
        sel_d   = sel;
        valid_d = valid;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    last_d  = pick;
                    grant_d = onehot(pick);
                    sel_d   = pick;
                    valid_d = 1'b1;
                end
            end
            OWNED: begin
                if (!req[sel] || timeout) begin
                    if (found) begin
                        last_d  = pick;
                        grant_d = onehot(pick);
                        sel_d   = pick;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        sel_d   = 2'd0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mux4 #(.W(WIDTH)) u_mux (
        .d0 (in0),
        .d1 (in1),
        .d2 (in2),
        .d3 (in3),
        .s  (sel),
        .y  (mux_y)
    );

    assign dout = valid ? mux_y : '0;

endmodule
